pwm_multichannel_ctrl: RTL

//   Parametrised multi-channel PWM generator: the successor to the fixed 16-channel,

---
 rtl/pwm_multichannel_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/pwm_multichannel_ctrl.sv
// Multi-channel PWM generator with a shared prescaler and period counter.
// Period, prescale and per-channel duty are double-buffered and take effect only at counter wrap.
module pwm_multichannel_ctrl #(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     en_out,
    input  logic [NUM_CH-1:0]     en_pwm,
    input  logic [CNT_W-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  duty_wr_en,
    input  logic [CH_W-1:0]       duty_wr_ch,
    input  logic [CNT_W-1:0]      duty_wr_data,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_tick
);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [PRESCALE_W-1:0] prescale_act;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      period_act;
    logic                  tick;
    logic                  wrap;
    logic                  wr_valid;
    logic [NUM_CH-1:0]     raw;
    logic [NUM_CH-1:0]     pwm_nxt;

    assign tick     = (presc_cnt == prescale_act);
    assign wrap     = tick && (cnt == period_act);
    assign wr_valid = duty_wr_en && (32'(duty_wr_ch) < NUM_CH);

    // Prescaler, period counter and the active timing configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt    <= '0;
            prescale_act <= '0;
            cnt          <= '0;
            period_act   <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
            if (tick) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
            if (wrap) begin
                period_act   <= period;
                prescale_act <= prescale;
            end
        end
    end

    // Per-channel duty shadow/active pair and compare.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             wr_hit;
        logic [CNT_W-1:0] duty_shadow;
        logic [CNT_W-1:0] duty_act;

        assign wr_hit = wr_valid && (duty_wr_ch == CH_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                duty_shadow <= '0;
                duty_act    <= '0;
            end else begin
                if (wr_hit) begin
                    duty_shadow <= duty_wr_data;
                end
                // A write landing on the wrap cycle bypasses the shadow.
                if (wrap) begin
                    duty_act <= wr_hit ? duty_wr_data : duty_shadow;
                end
            end
        end

        assign raw[i]     = (cnt < duty_act);
        assign pwm_nxt[i] = en_out[i] & (~en_pwm[i] | raw[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= pwm_nxt;
            period_tick <= wrap;
        end
    end

endmodule
